// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch unit and its skid FIFO.
// Instruction space starts at 0x4000_0000; sequential fetches step one 32-bit word.
package instruction_fetch_unit_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam logic [31:0] RESET_PC_DEF     = 32'h4000_0000;
  localparam int unsigned PC_STEP_DEF      = 4;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;
  localparam int unsigned PTR_W            = $clog2(FETCH_FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W       = $clog2(FETCH_FIFO_DEPTH + 1);
  localparam int unsigned OCC_W            = FIFO_CNT_W + 1;

  // Slots that will be in use after this cycle: buffered + in flight - leaving.
  function automatic logic [OCC_W-1:0] fetch_occupancy(
    input logic [FIFO_CNT_W-1:0] count,
    input logic                  in_flight,
    input logic                  pop
  );
    return {1'b0, count} + {{FIFO_CNT_W{1'b0}}, in_flight} - {{FIFO_CNT_W{1'b0}}, pop};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory read port and decode handshake of the fetch stage.
// master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned N = ADDR_W
);

  logic [N-1:0] mem_addr;
  logic         mem_wr_ena;
  logic [N-1:0] mem_rdata;
  logic         inst_valid;
  logic         inst_ready;
  logic [N-1:0] inst_data;
  logic [N-1:0] inst_pc;

  modport master (
    output mem_addr,
    output mem_wr_ena,
    input  mem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_ena,
    output mem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );

endinterface

// File: rtl/instruction_fetch_unit_skid_fifo.sv
// Two-entry {pc, data} FIFO between the memory response and decode.
// Flush empties it and wins over a same-cycle push; head is read straight from storage.
module instruction_fetch_unit_skid_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned N = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  push,
  input  logic [N-1:0]          push_pc,
  input  logic [N-1:0]          push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  head_valid,
  output logic [N-1:0]          head_pc,
  output logic [N-1:0]          head_data
);

  logic [N-1:0]          pc_mem_r   [FETCH_FIFO_DEPTH];
  logic [N-1:0]          data_mem_r [FETCH_FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [FIFO_CNT_W-1:0] count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Guard against underflow and overflow regardless of the caller's discipline.
  always_comb begin
    pop_ok_s  = pop & (count_r != {FIFO_CNT_W{1'b0}});
    push_ok_s = push & ((count_r != FIFO_CNT_W'(FETCH_FIFO_DEPTH)) | pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      pc_mem_r   <= '{default: {N{1'b0}}};
      data_mem_r <= '{default: {N{1'b0}}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {FIFO_CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {FIFO_CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        pc_mem_r[wr_ptr_r]   <= push_pc;
        data_mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
        2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head view comes only from registers.
  always_comb begin
    count      = count_r;
    head_valid = (count_r != {FIFO_CNT_W{1'b0}});
    head_pc    = pc_mem_r[rd_ptr_r];
    head_data  = data_mem_r[rd_ptr_r];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: sequential word PCs into a 1-cycle-latency memory, responses buffered
// in a 2-entry skid FIFO for decode, with redirect that flushes stale fetches.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned  N        = ADDR_W,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEF),
  parameter int unsigned  PC_STEP  = PC_STEP_DEF
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        fetch_en,
  input  logic                        redirect_valid,
  input  logic [N-1:0]                redirect_pc,
  instruction_fetch_unit_if.master    bus
);

  logic [N-1:0]          pc_r;
  logic                  req_r;
  logic [N-1:0]          req_pc_r;
  logic                  pop_s;
  logic                  issue_s;
  logic [OCC_W-1:0]      occ_s;
  logic [FIFO_CNT_W-1:0] fifo_count_s;
  logic                  fifo_valid_s;
  logic [N-1:0]          fifo_pc_s;
  logic [N-1:0]          fifo_data_s;

  // Only issue when a FIFO slot is guaranteed for the word one cycle later.
  always_comb begin
    pop_s   = fifo_valid_s & bus.inst_ready;
    occ_s   = fetch_occupancy(fifo_count_s, req_r, pop_s);
    issue_s = fetch_en & ~redirect_valid & (occ_s <= OCC_W'(1));
  end

  // PC and in-flight request tracking; redirect has priority over issue.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      pc_r     <= RESET_PC;
      req_r    <= 1'b0;
      req_pc_r <= {N{1'b0}};
    end else if (redirect_valid) begin
      pc_r     <= redirect_pc & ~(N'(3));
      req_r    <= 1'b0;
    end else if (issue_s) begin
      pc_r     <= pc_r + N'(PC_STEP);
      req_r    <= 1'b1;
      req_pc_r <= pc_r;
    end else begin
      req_r    <= 1'b0;
    end
  end

  instruction_fetch_unit_skid_fifo #(
    .N (N)
  ) u_fifo (
    .clk        (clk),
    .rstb       (rstb),
    .push       (req_r),
    .push_pc    (req_pc_r),
    .push_data  (bus.mem_rdata),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .count      (fifo_count_s),
    .head_valid (fifo_valid_s),
    .head_pc    (fifo_pc_s),
    .head_data  (fifo_data_s)
  );

  // Bus outputs: address is the pc register, decode side is the FIFO head.
  always_comb begin
    bus.mem_addr   = pc_r;
    bus.mem_wr_ena = 1'b0;
    bus.inst_valid = fifo_valid_s;
    bus.inst_pc    = fifo_pc_s;
    bus.inst_data  = fifo_data_s;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle-exact vector table for the directed
// scenarios, then random traffic checked against an instruction-stream model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk;
  logic        rstb;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  int          n_checks;
  int          n_errors;

  instruction_fetch_unit_if #(.N(32)) bus ();

  instruction_fetch_unit dut (
    .clk            (clk),
    .rstb           (rstb),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: IMEM word i (from 0x4000_0000) holds i + 0x100.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    logic [31:0] off;
    off = a - B;
    return (off >> 2) + 32'h0000_0100;
  endfunction

  // Registered-read memory: data appears the cycle after the address.
  always @(posedge clk) bus.mem_rdata <= mem_f(bus.mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        rb;
    logic        ev;
    logic        chk;
    logic [31:0] epc;
    logic [31:0] edata;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic rb, input logic ev, input logic chk, input logic [31:0] epc,
                     input logic [31:0] edata, input logic [31:0] eaddr);
    vec_t v;
    v = '{fe, rdy, rv, rpc, rb, ev, chk, epc, edata, eaddr};
    vecs.push_back(v);
  endtask

  logic        v_s;
  logic [31:0] p_s;
  logic [31:0] d_s;
  logic        pop_m;
  logic        hold_m;
  logic [31:0] hold_pc_m;
  logic [31:0] hold_data_m;
  logic [31:0] exp_pc_m;
  int          gap_m;

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rstb           = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus.inst_ready = 1'b0;

    // fe rdy rv rpc rb | ev chk pc data mem_addr  (outputs observed in the same cycle)
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, B);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, B + 32'h4);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B, 32'h100, B + 32'h8);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h4, 32'h101, B + 32'hC);
    for (int k = 0; k < 5; k++)
      add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h8, 32'h102, B + 32'h10);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h8, 32'h102, B + 32'h10);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'hC, 32'h103, B + 32'h14);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h10, 32'h104, B + 32'h18);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h14, 32'h105, B + 32'h1C);
    // redirect with one buffered and one in flight
    add(1'b1, 1'b0, 1'b1, B + 32'h43, 1'b1, 1'b1, 1'b1, B + 32'h18, 32'h106, B + 32'h20);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, B + 32'h40);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, B + 32'h44);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h40, 32'h110, B + 32'h48);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h44, 32'h111, B + 32'h4C);
    // back-to-back redirects: only the second target survives
    add(1'b1, 1'b1, 1'b1, B + 32'h100, 1'b1, 1'b1, 1'b1, B + 32'h48, 32'h112, B + 32'h50);
    add(1'b1, 1'b1, 1'b1, B + 32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, B + 32'h100);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, B + 32'h200);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, B + 32'h204);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h200, 32'h180, B + 32'h208);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h204, 32'h181, B + 32'h20C);
    // reset during a full stall
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B + 32'h208, 32'h182, B + 32'h210);
    add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, B + 32'h208, 32'h182, B + 32'h210);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, B);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, B + 32'h4);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, B, 32'h100, B + 32'h8);
    // wrap at the top of the address space, then fetch_en low
    add(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, B + 32'h4, 32'h101, B + 32'hC);
    add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h3000_00FF, 32'h0);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("v%0d_valid", i), {31'd0, bus.inst_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].eaddr);
      check($sformatf("v%0d_wr_ena", i), {31'd0, bus.mem_wr_ena}, 32'd0);
      if (vecs[i].chk) begin
        check($sformatf("v%0d_pc", i), bus.inst_pc, vecs[i].epc);
        check($sformatf("v%0d_data", i), bus.inst_data, vecs[i].edata);
      end
      fetch_en       = vecs[i].fe;
      bus.inst_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      rstb           = vecs[i].rb;
    end

    // Random traffic: every accepted instruction must be the next one of the current stream.
    hold_m      = 1'b0;
    hold_pc_m   = 32'h0;
    hold_data_m = 32'h0;
    exp_pc_m    = B;
    gap_m       = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      v_s = bus.inst_valid;
      p_s = bus.inst_pc;
      d_s = bus.inst_data;
      if (hold_m) begin
        check("stall_valid", {31'd0, v_s}, 32'd1);
        check("stall_pc", p_s, hold_pc_m);
        check("stall_data", d_s, hold_data_m);
      end
      fetch_en       = ($urandom_range(9, 0) < 8);
      bus.inst_ready = ($urandom_range(9, 0) < 6);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom;
      rstb           = (c == 0) ? 1'b0 : ($urandom_range(199, 0) != 0);
      pop_m          = v_s & bus.inst_ready;
      if (!rstb) begin
        exp_pc_m = B;
      end else begin
        if (pop_m) begin
          check("rnd_pc", p_s, exp_pc_m);
          check("rnd_data", d_s, mem_f(p_s));
          exp_pc_m = exp_pc_m + 32'h4;
        end
        if (redirect_valid) exp_pc_m = {redirect_pc[31:2], 2'b00};
      end
      hold_m      = v_s & ~bus.inst_ready & ~redirect_valid & rstb;
      hold_pc_m   = p_s;
      hold_data_m = d_s;
      if (fetch_en & bus.inst_ready & ~redirect_valid & rstb) begin
        gap_m = pop_m ? 0 : gap_m + 1;
        check("rnd_throughput_gap", {31'd0, (gap_m > 2)}, 32'd0);
      end else begin
        gap_m = 0;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
